enigma_ctrl: RTL and testbench

ENIGMA_CTRL -- requirements
Module: enigma_ctrl

---
 rtl/enigma_ctrl_if.sv | 20 ++
 rtl/enigma_ctrl.sv | 124 ++++++++++++
 tb/tb_enigma_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/enigma_ctrl_if.sv
// Byte-stream handshake bundle between a host and the enigma controller.
// The host is the master; the controller is the slave on both streams.
interface enigma_ctrl_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/enigma_ctrl.sv
// ASCII front end for an Enigma cipher core: letters are sent to the core,
// other bytes are echoed unchanged, and a space is inserted every GROUP letters.
module enigma_ctrl #(
  parameter int unsigned GROUP = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              msg_start,
  enigma_ctrl_if.slave      bus,
  output logic              core_rst,
  output logic              core_valid_in,
  output logic [4:0]        core_char_in,
  input  logic              core_valid_out,
  input  logic [4:0]        core_char_out,
  output logic [15:0]       char_count,
  output logic              err
);

  localparam int unsigned GW = (GROUP > 0) ? $clog2(GROUP + 1) : 1;

  localparam logic [2:0] CLR  = 3'd0;
  localparam logic [2:0] IDLE = 3'd1;
  localparam logic [2:0] FEED = 3'd2;
  localparam logic [2:0] WAIT = 3'd3;
  localparam logic [2:0] OUT  = 3'd4;
  localparam logic [2:0] SEP  = 3'd5;

  logic [2:0]    state, state_n;
  logic [4:0]    code, code_n;
  logic [7:0]    out_data, out_data_n;
  logic [15:0]   cnt, cnt_n;
  logic [GW-1:0] grp, grp_n;
  logic          err_q, err_n;

  logic is_upper, is_lower;

  assign is_upper = (bus.in_data >= 8'h41) && (bus.in_data <= 8'h5A);
  assign is_lower = (bus.in_data >= 8'h61) && (bus.in_data <= 8'h7A);

  // Output decodes of the state register
  assign core_rst      = (state == CLR);
  assign core_valid_in = (state == FEED);
  assign core_char_in  = code;
  assign bus.in_ready  = (state == IDLE) && !msg_start;
  assign bus.out_valid = (state == OUT) || (state == SEP);
  assign bus.out_data  = out_data;
  assign char_count    = cnt;
  assign err           = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLR;
      code     <= '0;
      out_data <= '0;
      cnt      <= '0;
      grp      <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      code     <= code_n;
      out_data <= out_data_n;
      cnt      <= cnt_n;
      grp      <= grp_n;
      err_q    <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    code_n     = code;
    out_data_n = out_data;
    cnt_n      = cnt;
    grp_n      = grp;
    err_n      = err_q;
    case (state)
      CLR: state_n = IDLE;
      IDLE: begin
        // A message start wins over a byte offered in the same cycle
        if (msg_start) begin
          state_n = CLR;
          cnt_n   = '0;
          grp_n   = '0;
        end else if (bus.in_valid) begin
          if (is_upper) begin
            code_n  = 5'(bus.in_data - 8'h41);
            state_n = FEED;
          end else if (is_lower) begin
            code_n  = 5'(bus.in_data - 8'h61);
            state_n = FEED;
          end else begin
            out_data_n = bus.in_data;
            state_n    = OUT;
          end
        end
      end
      FEED: state_n = WAIT;
      WAIT: begin
        if (core_valid_out && (core_char_out <= 5'd25)) begin
          out_data_n = 8'(8'h41 + 8'(core_char_out));
        end else begin
          out_data_n = 8'h3F;
          err_n      = 1'b1;
        end
        if (cnt != 16'hFFFF) cnt_n = 16'(cnt + 16'd1);
        grp_n   = GW'(grp + GW'(1));
        state_n = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          if ((GROUP != 0) && (grp == GW'(GROUP))) begin
            grp_n      = '0;
            out_data_n = 8'h20;
            state_n    = SEP;
          end else begin
            state_n = IDLE;
          end
        end
      end
      SEP: if (bus.out_ready) state_n = IDLE;
      default: state_n = CLR;
    endcase
  end

endmodule

// File: tb/tb_enigma_ctrl.sv
// Directed and randomized bench for enigma_ctrl with stub, silent and
// three-rotor Enigma core models; outputs are scored against a byte-level model.
module tb_enigma_ctrl;
  localparam int unsigned GROUP = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        msg_start;
  logic        core_rst, core_valid_in, core_valid_out;
  logic [4:0]  core_char_in, core_char_out;
  logic [15:0] char_count;
  logic        err;

  enigma_ctrl_if bus();

  enigma_ctrl #(.GROUP(GROUP)) dut (
    .clk            (clk),
    .rst            (rst),
    .msg_start      (msg_start),
    .bus            (bus),
    .core_rst       (core_rst),
    .core_valid_in  (core_valid_in),
    .core_char_in   (core_char_in),
    .core_valid_out (core_valid_out),
    .core_char_out  (core_char_out),
    .char_count     (char_count),
    .err            (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mode;     // 0: stub (+1), 1: Enigma I/II/III with reflector B, 2: never valid
  bit bp_en;

  // ---------------- core models ----------------
  string       rw [4] = '{"EKMFLGDQVZNTOWYHXUSPAIBRCJ", "AJDKSIRUXBLHWTMCQGZNPYFVOE",
                          "BDFHJLCPRTXVZNYEGIWAKMUSQO", "YRUHQSLDPXNGOKMIEBFZCWVJAT"};
  logic [14:0] rpos;

  function automatic int fwd(input int r, input int c, input int p);
    return (int'(rw[r].getc((c + p) % 26)) - 65 - p + 26) % 26;
  endfunction

  function automatic int inv(input int r, input int c, input int p);
    int t, j;
    t = (c + p) % 26;
    j = 0;
    for (int k = 0; k < 26; k++) if (int'(rw[r].getc(k)) - 65 == t) j = k;
    return (j - p + 26) % 26;
  endfunction

  function automatic logic [14:0] step_pos(input logic [14:0] p);
    int a, b, d;
    a = int'(p[4:0]); b = int'(p[9:5]); d = int'(p[14:10]);
    if (b == 4) begin a = (a + 1) % 26; b = (b + 1) % 26; end
    else if (d == 21) b = (b + 1) % 26;
    d = (d + 1) % 26;
    return {5'(d), 5'(b), 5'(a)};
  endfunction

  function automatic logic [4:0] enc(input logic [14:0] p, input logic [4:0] c);
    int x;
    int pr [3];
    pr[0] = int'(p[4:0]); pr[1] = int'(p[9:5]); pr[2] = int'(p[14:10]);
    x = int'(c);
    for (int r = 2; r >= 0; r--) x = fwd(r, x, pr[r]);
    x = int'(rw[3].getc(x)) - 65;
    for (int r = 0; r < 3; r++) x = inv(r, x, pr[r]);
    return 5'(x);
  endfunction

  always @(posedge clk) begin
    if (core_rst) begin
      rpos           <= '0;
      core_valid_out <= 1'b0;
      core_char_out  <= '0;
    end else begin
      core_valid_out <= core_valid_in && (mode != 2);
      if (core_valid_in) begin
        rpos          <= step_pos(rpos);
        core_char_out <= (mode == 1) ? enc(step_pos(rpos), core_char_in)
                                     : 5'((int'(core_char_in) + 1) % 26);
      end
    end
  end

  // ---------------- monitor ----------------
  logic [7:0] got [$];
  int cvi_n  = 0;
  int crst_n = 0;

  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
    if (core_valid_in) cvi_n <= cvi_n + 1;
    if (core_rst)      crst_n <= crst_n + 1;
  end

  // ---------------- reference model ----------------
  logic [7:0] exp_q [$];
  int mdl_cnt, mdl_grp, gbase;

  task automatic model_byte(input logic [7:0] b);
    int code;
    code = -1;
    if (b >= 8'h41 && b <= 8'h5A) code = int'(b) - 65;
    if (b >= 8'h61 && b <= 8'h7A) code = int'(b) - 97;
    if (code < 0) exp_q.push_back(b);
    else begin
      exp_q.push_back((mode == 2) ? 8'h3F : 8'(65 + (code + 1) % 26));
      mdl_cnt++;
      mdl_grp++;
      if (GROUP != 0 && mdl_grp == int'(GROUP)) begin
        exp_q.push_back(8'h20);
        mdl_grp = 0;
      end
    end
  endtask

  task automatic model_clear();
    mdl_cnt = 0;
    mdl_grp = 0;
    exp_q.delete();
    gbase = got.size();
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bp_en) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit want_lat, output int lat);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && n < 200) begin tick(); n++; end
    if (n >= 200) check("accept_timeout", 32'(n), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    if (want_lat) while (!bus.out_valid && lat < 50) begin tick(); lat++; end
  endtask

  task automatic wait_got(input int n);
    int t;
    t = 0;
    while (!(got.size() >= gbase + n && bus.in_ready) && t < 3000) begin tick(); t++; end
    if (t >= 3000) check("drain_timeout", 32'(got.size() - gbase), 32'(n));
  endtask

  task automatic drain_compare(input string tag);
    wait_got(exp_q.size());
    check({tag, "_len"}, 32'(got.size() - gbase), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && gbase + i < got.size(); i++)
      check(tag, {24'd0, got[gbase + i]}, {24'd0, exp_q[i]});
    gbase = got.size();
    exp_q.delete();
  endtask

  task automatic start_msg();
    int n;
    n = 0;
    while (!bus.in_ready && n < 200) begin tick(); n++; end
    msg_start = 1'b1;
    tick();
    msg_start = 1'b0;
    tick();
    mdl_cnt = 0;
    mdl_grp = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, c0, v0, nlet;
    logic [7:0] b, held;
    logic [7:0] cipher [$];
    string s;

    mode = 0; bp_en = 1'b0; msg_start = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b1;
    rst = 1'b0;
    #2 rst = 1'b1;
    tick(); tick();
    check("rst_core_rst",  32'(core_rst), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data), 32'd0);
    check("rst_cvi",       32'(core_valid_in), 32'd0);
    check("rst_char_in",   32'(core_char_in), 32'd0);
    check("rst_count",     32'(char_count), 32'd0);
    check("rst_err",       32'(err), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    check("clr_after_rst", 32'(core_rst), 32'd1);
    tick();
    check("idle_core_rst", 32'(core_rst), 32'd0);
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    model_clear();

    // single lowercase letter through the stub core
    model_byte(8'h61);
    send_byte(8'h61, 1'b1, lat);
    check("a_latency", 32'(lat), 32'd2);
    check("a_out_data", 32'(bus.out_data), 32'h42);
    drain_compare("a_out");
    check("a_count", 32'(char_count), 32'd1);

    // six letters with grouping
    start_msg();
    v0 = cvi_n;
    s = "ABCDEF";
    for (int i = 0; i < s.len(); i++) begin
      b = 8'(s.getc(i));
      model_byte(b);
      send_byte(b, 1'b0, lat);
    end
    drain_compare("group_out");
    check("group_count", 32'(char_count), 32'd6);
    check("group_cvi", 32'(cvi_n - v0), 32'd6);

    // non-letters echo without touching the core
    v0 = cvi_n;
    model_byte(8'h33);
    send_byte(8'h33, 1'b1, lat);
    check("digit_latency", 32'(lat), 32'd0);
    model_byte(8'h20);
    send_byte(8'h20, 1'b1, lat);
    check("space_latency", 32'(lat), 32'd0);
    drain_compare("echo_out");
    check("echo_cvi", 32'(cvi_n - v0), 32'd0);
    check("echo_count", 32'(char_count), 32'd6);

    // backpressure in OUT; msg_start there must be ignored
    bus.out_ready = 1'b0;
    model_byte(8'h63);
    send_byte(8'h63, 1'b1, lat);
    held = bus.out_data;
    check("bp_first", 32'(held), 32'h44);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) msg_start = 1'b1;
      tick();
      msg_start = 1'b0;
      check("bp_stable", 32'(bus.out_data), 32'(held));
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    check("bp_valid", 32'(bus.out_valid), 32'd1);
    check("bp_count", 32'(char_count), 32'd7);
    bus.out_ready = 1'b1;
    drain_compare("bp_out");

    // real Enigma core: encrypt, restart, decrypt
    mode = 1;
    c0 = crst_n;
    start_msg();
    check("msg_core_rst_1", 32'(crst_n - c0), 32'd1);
    gbase = got.size();
    s = "HELLOWORLD";
    for (int i = 0; i < s.len(); i++) send_byte(8'(s.getc(i)), 1'b0, lat);
    wait_got(12);
    cipher.delete();
    for (int i = 0; i < 12; i++) cipher.push_back(got[gbase + i]);
    gbase = got.size();
    check("cipher_sep", 32'(cipher[5]), 32'h20);
    c0 = crst_n;
    start_msg();
    check("msg_core_rst_2", 32'(crst_n - c0), 32'd1);
    s = "HELLO WORLD ";
    for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s.getc(i)));
    for (int i = 0; i < 11; i++) if (i != 5) send_byte(cipher[i], 1'b0, lat);
    drain_compare("decrypt");
    check("decrypt_count", 32'(char_count), 32'd10);

    // silent core sets a sticky error
    mode = 2;
    start_msg();
    model_byte(8'h78);
    send_byte(8'h78, 1'b0, lat);
    drain_compare("silent_out");
    check("err_set", 32'(err), 32'd1);
    start_msg();
    check("err_sticky", 32'(err), 32'd1);

    // reset while a letter is in flight
    mode = 0;
    model_clear();
    send_byte(8'h71, 1'b0, lat);
    rst = 1'b1;
    tick();
    check("abort_err", 32'(err), 32'd0);
    check("abort_count", 32'(char_count), 32'd0);
    check("abort_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    tick(); tick(); tick();
    check("abort_no_out", 32'(got.size() - gbase), 32'd0);

    // randomized bytes with random backpressure
    model_clear();
    start_msg();
    bp_en = 1'b1;
    v0 = cvi_n;
    nlet = 0;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: b = 8'(65 + $urandom_range(0, 25));
        1: b = 8'(97 + $urandom_range(0, 25));
        2: b = 8'(32 + $urandom_range(0, 32));
        default: b = 8'($urandom_range(0, 255));
      endcase
      if ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A)) nlet++;
      model_byte(b);
      send_byte(b, 1'b0, lat);
    end
    drain_compare("rand_out");
    check("rand_count", 32'(char_count), 32'(mdl_cnt));
    check("rand_cvi", 32'(cvi_n - v0), 32'(nlet));
    bp_en = 1'b0;
    bus.out_ready = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
